// File: rtl/pc_gen_pkg.sv
// Core-wide constants and FSM encoding shared by the program-counter/fetch logic.
package pc_gen_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: sequential, PC-relative branch/jal, or register-relative jalr,
// plus detection of a taken target that is not word aligned.
module pc_next_mux
  import pc_gen_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            PC_src,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // Adds wrap modulo 2^32; jalr clears bit 0 of its target like the ISA requires.
  always_comb begin
    next_pc = pc + 32'd4;
    if (PC_src) begin
      if (jalr) begin
        next_pc = (rs1_data + imm) & ~32'h1;
      end else begin
        next_pc = pc + imm;
      end
    end
  end

  // Only taken targets can trap; the sequential path is always aligned.
  assign misaligned = PC_src & next_pc[1];

endmodule

// File: rtl/pc_gen.sv
// Program counter, next-PC generation and the FETCH/EXEC sequencer that talks to
// instruction memory for the unpipelined core.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PC_src,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_trap
);

  pc_state_t       state;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  pc_next_mux u_next_mux (
    .pc         (pc),
    .PC_src     (PC_src),
    .jalr       (jalr),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // imem_req/instr_valid are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RST;
      pc            <= RESET_VECTOR;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= 1'b0;
      case (state)
        RST: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            if (misaligned) begin
              pc            <= TRAP_VECTOR;
              misalign_trap <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        default: begin
          state       <= RST;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed instruction table, hand-written corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        PC_src;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_trap;

  int checks;
  int errors;

  // Reference model: which phase of the instruction lifecycle we are in
  // (0 = coming out of reset, 1 = waiting for memory, 2 = executing).
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_trap;

  typedef struct {
    logic        src;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_pc;
    logic        exp_trap;
  } vec_t;

  vec_t vecs[12];

  pc_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_src        (PC_src),
    .jalr          (jalr),
    .imm           (imm),
    .rs1_data      (rs1_data),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .misalign_trap (misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference model by one rising edge using the currently driven inputs.
  task automatic modelStep();
    logic [31:0] target;
    if (!rst_n) begin
      m_phase = 0;
      m_pc    = RESET_PC;
      m_trap  = 1'b0;
      return;
    end
    m_trap = 1'b0;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (imem_ready) m_phase = 2;
    end else if (!stall) begin
      if (!PC_src)    target = m_pc + 32'd4;
      else if (!jalr) target = m_pc + imm;
      else            target = {rs1_data[31:1] + imm[31:1] + 31'(rs1_data[0] & imm[0]), 1'b0};
      if (PC_src && target[1]) begin
        m_pc   = TRAP_PC;
        m_trap = 1'b1;
      end else begin
        m_pc = target;
      end
      m_phase = 1;
    end
  endtask

  task automatic checkOutput();
    check32("imem_req",      32'(imem_req),      32'(m_phase == 1));
    check32("instr_valid",   32'(instr_valid),   32'(m_phase == 2));
    check32("pc",            pc,                 m_pc);
    check32("imem_addr",     imem_addr,          m_pc);
    check32("pc_plus4",      pc_plus4,           m_pc + 32'd4);
    check32("misalign_trap", 32'(misalign_trap), 32'(m_trap));
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
  task automatic applyStimulus(input logic src, input logic jr, input logic [31:0] im,
                               input logic [31:0] rs1, input logic stl, input logic rdy);
    PC_src     = src;
    jalr       = jr;
    imm        = im;
    rs1_data   = rs1;
    stall      = stl;
    imem_ready = rdy;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelStep();
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] cur_pc;
    logic [31:0] held_pc;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    PC_src = 0; jalr = 0; imm = 0; rs1_data = 0; stall = 0; imem_ready = 0;
    m_phase = 0; m_pc = RESET_PC; m_trap = 0;

    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0008, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_00F8, 32'h0000_0000, 32'h0000_0100, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_00F0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_2001, 32'h0000_2004, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000, 32'h0000_0100, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000_0003, 32'h0000_0104, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0002, 32'h0000_0010, 32'h0000_0100, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FEFC, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

    @(negedge clk);
    doReset();
    check32("reset_release_req", 32'(imem_req), 32'h1);

    // Directed table: each record is one full FETCH+EXEC instruction.
    cur_pc = RESET_PC;
    for (int i = 0; i < 12; i++) begin
      check32("tbl_fetch_addr", imem_addr, cur_pc);
      applyStimulus(0, 0, 0, 0, 0, 1);
      check32("tbl_exec_valid", 32'(instr_valid), 32'h1);
      check32("tbl_exec_plus4", pc_plus4, cur_pc + 32'd4);
      applyStimulus(vecs[i].src, vecs[i].jalr, vecs[i].imm, vecs[i].rs1, 0, 0);
      check32("tbl_next_pc", pc, vecs[i].exp_pc);
      check32("tbl_trap", 32'(misalign_trap), 32'(vecs[i].exp_trap));
      cur_pc = vecs[i].exp_pc;
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    check32("trap_pulse_gone", 32'(misalign_trap), 32'h0);

    // Stall held for three EXEC cycles, then release fetches pc+4.
    applyStimulus(0, 0, 0, 0, 0, 1);
    held_pc = pc;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h40, 0, 1, 1);
      check32("stall_pc_held", pc, held_pc);
      check32("stall_valid", 32'(instr_valid), 32'h1);
      check32("stall_no_req", 32'(imem_req), 32'h0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    check32("stall_release_addr", imem_addr, held_pc + 32'd4);

    // Memory not ready for four cycles: request and address must stay put; stall in FETCH is ignored.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 32'h8, 32'h8, 1, 0);
      check32("wait_req", 32'(imem_req), 32'h1);
      check32("wait_addr", imem_addr, held_pc + 32'd4);
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    check32("fetch_stall_ignored", 32'(instr_valid), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Asynchronous reset while a fetch request is outstanding.
    check32("pre_reset_req", 32'(imem_req), 32'h1);
    doReset();
    check32("post_reset_pc", pc, RESET_PC);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32),
                    $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
